// File: rtl/dmem_store_buffered.sv
// dmem_store_buffered: word-addressed data RAM behind the core's MEM stage.
// Core stores are posted into a small store buffer and drained to the single
// RAM port when it is free. Loads are forwarded from the youngest matching
// buffered store. A debug/loader port shares the same RAM port.
// Build option DMEM_STBUF_EN enables the store buffer. Without it, core stores
// write the RAM directly and debug accesses only use edges the core leaves idle.
module dmem_store_buffered #(
  parameter int DEPTH    = 1024,
  parameter int SB_DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RSTa,
  input  logic [31:0]               mem_addr,
  input  logic [31:0]               mem_wdata,
  input  logic                      mem_we,
  input  logic                      mem_re,
  output logic [31:0]               mem_rdata,
  input  logic                      dbg_req,
  input  logic                      dbg_we,
  input  logic [31:0]               dbg_addr,
  input  logic [31:0]               dbg_wdata,
  output logic                      dbg_ack,
  output logic [31:0]               dbg_rdata,
  output logic [$clog2(SB_DEPTH):0] sb_count,
  output logic                      sb_full
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   ram [DEPTH];
  logic          core_inr, dbg_inr;
  logic [AW-1:0] core_idx, dbg_idx;
  logic          core_st, core_ld;
  logic          dbg_gnt;
  logic          core_hit, dbg_hit;
  logic [31:0]   core_fwd, dbg_fwd;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   mem_rdata_q, dbg_rdata_q;
  logic          dbg_ack_q;
  logic [3:0]    unused_addr_bits;

  // Byte offset bits are irrelevant for word accesses.
  assign unused_addr_bits = {mem_addr[1:0], dbg_addr[1:0]};

  assign core_inr = (mem_addr[31:AW+2] == '0);
  assign dbg_inr  = (dbg_addr[31:AW+2] == '0);
  assign core_idx = mem_addr[AW+1:2];
  assign dbg_idx  = dbg_addr[AW+1:2];
  // A cycle with both strobes high is a store; out-of-range stores vanish.
  assign core_st  = mem_we & core_inr;
  assign core_ld  = mem_re & ~mem_we;

`ifdef DMEM_STBUF_EN
  localparam int PW = $clog2(SB_DEPTH);

  logic [AW-1:0]       sb_idx_q [SB_DEPTH];
  logic [31:0]         sb_dat_q [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_vld;
  logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [PW:0]         count_q, count_d;
  logic                full, ld_gnt, fdrain, ndrain, drain, dbg_wr;

  assign full     = (count_q == (PW+1)'(SB_DEPTH));
  // RAM port priority: core load, forced drain, debug, background drain.
  assign ld_gnt   = core_ld & core_inr;
  assign fdrain   = ~ld_gnt & full & core_st;
  assign dbg_gnt  = ~ld_gnt & ~fdrain & dbg_req & ~dbg_ack_q;
  assign ndrain   = ~ld_gnt & ~fdrain & ~dbg_gnt & (count_q != '0);
  assign drain    = fdrain | ndrain;
  assign dbg_wr   = dbg_gnt & dbg_we & dbg_inr;
  assign sb_count = count_q;
  assign sb_full  = full;

  // Walk live entries oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] pos;
    pos      = '0;
    sb_vld   = '0;
    core_hit = 1'b0;
    core_fwd = '0;
    dbg_hit  = 1'b0;
    dbg_fwd  = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      pos = head_q + PW'(k);
      if ((PW+1)'(k) < count_q) begin
        sb_vld[pos] = 1'b1;
        if (sb_idx_q[pos] == core_idx) begin
          core_hit = 1'b1;
          core_fwd = sb_dat_q[pos];
        end
        if (sb_idx_q[pos] == dbg_idx) begin
          dbg_hit = 1'b1;
          dbg_fwd = sb_dat_q[pos];
        end
      end
    end
  end

  // Next pointers/occupancy; a forced drain and an enqueue cancel out.
  always_comb begin
    head_d  = head_q + PW'(drain);
    tail_d  = tail_q + PW'(core_st);
    count_d = count_q + (PW+1)'(core_st) - (PW+1)'(drain);
  end

  // RAM write source: head entry on a drain, otherwise a debug write.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = sb_idx_q[head_q];
    ram_wdata = sb_dat_q[head_q];
    if (drain) begin
      ram_we = 1'b1;
    end else if (dbg_wr) begin
      ram_we    = 1'b1;
      ram_waddr = dbg_idx;
      ram_wdata = dbg_wdata;
    end
  end

  // Buffer control state; reset discards every pending store.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Buffer payload: enqueue at tail; a debug write patches live matching entries.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < SB_DEPTH; i++) begin
      if (core_st && (tail_q == PW'(i))) begin
        sb_idx_q[i] <= core_idx;
        sb_dat_q[i] <= mem_wdata;
      end else if (dbg_wr && sb_vld[i] && (sb_idx_q[i] == dbg_idx)) begin
        sb_dat_q[i] <= dbg_wdata;
      end
    end
  end
`else
  // Without a buffer the core owns the port on any strobe.
  assign dbg_gnt  = dbg_req & ~dbg_ack_q & ~mem_re & ~mem_we;
  assign core_hit = 1'b0;
  assign dbg_hit  = 1'b0;
  assign core_fwd = '0;
  assign dbg_fwd  = '0;
  assign sb_count = '0;
  assign sb_full  = 1'b0;

  // Direct RAM write from a core store or a granted debug write.
  always_comb begin
    ram_we    = core_st | (dbg_gnt & dbg_we & dbg_inr);
    ram_waddr = core_st ? core_idx : dbg_idx;
    ram_wdata = core_st ? mem_wdata : dbg_wdata;
  end
`endif

  // Single RAM write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  // Read results and the debug handshake; load data lands on the load's own edge.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      mem_rdata_q <= '0;
      dbg_rdata_q <= '0;
      dbg_ack_q   <= 1'b0;
    end else begin
      dbg_ack_q <= dbg_gnt;
      if (core_ld) begin
        mem_rdata_q <= !core_inr ? 32'h0 : (core_hit ? core_fwd : ram[core_idx]);
      end
      if (dbg_gnt && !dbg_we) begin
        dbg_rdata_q <= !dbg_inr ? 32'h0 : (dbg_hit ? dbg_fwd : ram[dbg_idx]);
      end
    end
  end

  assign mem_rdata = mem_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign dbg_ack   = dbg_ack_q;

endmodule

// File: tb/tb_dmem_store_buffered.sv
// Bench for dmem_store_buffered: a queue/array model of the visible memory
// contents and the store buffer, checked on every negedge, plus literal
// expectations at the key points of the directed sequence.
module tb_dmem_store_buffered;
  localparam int DEPTH = 1024;
  localparam int SB    = 4;
`ifdef DMEM_STBUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RSTa = 1'b0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        mem_we = 1'b0, mem_re = 1'b0;
  logic [31:0] mem_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic [2:0]  sb_count;
  logic        sb_full;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_store_buffered #(.DEPTH(DEPTH), .SB_DEPTH(SB)) dut (
    .CLK(CLK), .RSTa(RSTa),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .sb_count(sb_count), .sb_full(sb_full)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, want %h", name, $time, act, exp);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int          q_idx[$];
  logic [31:0] q_dat[$];
  logic [31:0] mram [int];
  logic [31:0] m_rdata = '0, m_drdata = '0;
  logic        m_dack = 1'b0;

  function automatic bit inr(input logic [31:0] a);
    return (a >> 2) < 32'(DEPTH);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) & 32'(DEPTH - 1));
  endfunction

  // Newest visible value of a word: youngest queued store, else memory.
  function automatic logic [31:0] lookup(input int idx);
    for (int i = q_idx.size() - 1; i >= 0; i--)
      if (q_idx[i] == idx) return q_dat[i];
    if (mram.exists(idx)) return mram[idx];
    return 32'h0;
  endfunction

  task automatic model_step();
    bit st, ld, ldp, fdr, dg, ndr;
    int ci, di;
    if (!RSTa) begin
      q_idx.delete();
      q_dat.delete();
      m_rdata  = '0;
      m_drdata = '0;
      m_dack   = 1'b0;
      return;
    end
    ci  = idx_of(mem_addr);
    di  = idx_of(dbg_addr);
    st  = mem_we && inr(mem_addr);
    ld  = mem_re && !mem_we;
    ldp = ld && inr(mem_addr);
    if (BUF) begin
      fdr = !ldp && (q_idx.size() == SB) && st;
      dg  = !ldp && !fdr && dbg_req && !m_dack;
      ndr = !ldp && !fdr && !dg && (q_idx.size() != 0);
    end else begin
      fdr = 1'b0;
      ndr = 1'b0;
      dg  = dbg_req && !mem_re && !mem_we && !m_dack;
    end
    if (ld) m_rdata = inr(mem_addr) ? lookup(ci) : 32'h0;
    if (dg && !dbg_we) m_drdata = inr(dbg_addr) ? lookup(di) : 32'h0;
    if (fdr || ndr) begin
      mram[q_idx[0]] = q_dat[0];
      q_idx.delete(0);
      q_dat.delete(0);
    end
    if (dg && dbg_we && inr(dbg_addr)) begin
      mram[di] = dbg_wdata;
      foreach (q_idx[i]) if (q_idx[i] == di) q_dat[i] = dbg_wdata;
    end
    if (st) begin
      if (BUF) begin
        q_idx.push_back(ci);
        q_dat.push_back(mem_wdata);
      end else begin
        mram[ci] = mem_wdata;
      end
    end
    m_dack = dg;
  endtask

  initial forever begin
    @(posedge CLK or negedge RSTa);
    model_step();
  end

  // Compare every output against the model where the core would capture it.
  initial forever begin
    @(negedge CLK);
    chk("mem_rdata", mem_rdata, m_rdata);
    chk("dbg_ack",   32'(dbg_ack), 32'(m_dack));
    chk("dbg_rdata", dbg_rdata, m_drdata);
    chk("sb_count",  32'(sb_count), BUF ? 32'(q_idx.size()) : 32'd0);
    chk("sb_full",   32'(sb_full), 32'(BUF && (q_idx.size() == SB)));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit we, input bit re, input logic [31:0] a,
                     input logic [31:0] d, input bit dq);
    #1;
    mem_we = we; mem_re = re; mem_addr = a; mem_wdata = d; dbg_req = dq;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic dbg_xfer(input bit we, input logic [31:0] a, input logic [31:0] d);
    int t;
    #1;
    mem_we = 1'b0; mem_re = 1'b0;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (!dbg_ack && t < 50);
    chk("dbg_ack_wait", 32'(dbg_ack), 32'd1);
  endtask

  initial begin
    logic [31:0] pre [12];
    pre = '{32'h10, 32'h40, 32'h80, 32'h200, 32'h204, 32'h208,
            32'h20C, 32'h210, 32'h214, 32'h300, 32'h304, 32'h308};

    repeat (3) @(negedge CLK);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_sb_count",  32'(sb_count), 32'd0);
    chk("rst_dbg_ack",   32'(dbg_ack), 32'd0);
    #1 RSTa = 1'b1;
    @(negedge CLK);

    // Preload through the debug port, then read one word back.
    foreach (pre[i]) dbg_xfer(1'b1, pre[i], 32'hC0DE0000 | pre[i]);
    dbg_xfer(1'b0, 32'h304, 32'h0);
    chk("dbg_read_304", dbg_rdata, 32'hC0DE0304);
    idle(2);

    // Store then load the same word next cycle.
    cyc(1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0);
    cyc(1'b0, 1'b1, 32'h40, 32'h0, 1'b0);
    chk("fwd_deadbeef", mem_rdata, 32'hDEADBEEF);
    chk("fwd_buffered", 32'(sb_count), BUF ? 32'd1 : 32'd0);
    idle(3);

    // Two stores to one word, debug reads hold the port so both stay buffered.
    dbg_we = 1'b0; dbg_addr = 32'h304;
    cyc(1'b1, 1'b0, 32'h80, 32'h1, 1'b1);
    cyc(1'b0, 1'b1, 32'h40, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h80, 32'h2, 1'b1);
    cyc(1'b0, 1'b1, 32'h80, 32'h0, 1'b1);
    chk("fwd_youngest", mem_rdata, 32'h2);
    chk("two_buffered", 32'(sb_count), BUF ? 32'd2 : 32'd0);
    idle(4);

    // Fill the buffer, then force drains with further stores.
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'b0, 32'h200 + 32'(4 * i), 32'hA0000000 + 32'(i), 1'b1);
      if (i >= 3) begin
        chk("full_count", 32'(sb_count), BUF ? 32'd4 : 32'd0);
        chk("full_flag",  32'(sb_full),  BUF ? 32'd1 : 32'd0);
      end
      cyc(1'b0, 1'b1, 32'h200, 32'h0, 1'b1);
    end
    idle(6);
    chk("drained_count", 32'(sb_count), 32'd0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'h0, 1'b0);
      chk("six_in_ram", mem_rdata, 32'hA0000000 + 32'(i));
    end

    // Debug write overrides a still-buffered core store.
    cyc(1'b1, 1'b0, 32'h10, 32'h33, 1'b0);
    dbg_xfer(1'b1, 32'h10, 32'h55);
    cyc(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    chk("dbg_wr_fwd", mem_rdata, 32'h55);
    idle(3);
    cyc(1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    chk("dbg_wr_ram", mem_rdata, 32'h55);

    // Store+load strobes together act as a store; rdata holds.
    cyc(1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0);
    chk("we_re_hold", mem_rdata, 32'h55);
    cyc(1'b0, 1'b1, 32'h40, 32'h0, 1'b0);
    chk("we_re_store", mem_rdata, 32'h12345678);
    idle(3);

    // Out-of-range store is dropped, out-of-range load reads zero.
    cyc(1'b1, 1'b0, 32'h00100000, 32'h77, 1'b0);
    chk("oor_not_enq", 32'(sb_count), 32'd0);
    cyc(1'b0, 1'b1, 32'h00100000, 32'h0, 1'b0);
    chk("oor_load", mem_rdata, 32'h0);
    idle(2);

    // Reset with three stores buffered, one already drained.
    dbg_we = 1'b0; dbg_addr = 32'h10;
    cyc(1'b1, 1'b0, 32'h300, 32'hB0, 1'b1);
    cyc(1'b0, 1'b1, 32'h40,  32'h0,  1'b1);
    cyc(1'b1, 1'b0, 32'h304, 32'hB1, 1'b1);
    cyc(1'b0, 1'b1, 32'h40,  32'h0,  1'b1);
    cyc(1'b1, 1'b0, 32'h308, 32'hB2, 1'b1);
    chk("three_buffered", 32'(sb_count), BUF ? 32'd3 : 32'd0);
    idle(1);
    chk("mid_drain", 32'(sb_count), BUF ? 32'd2 : 32'd0);
    #1 RSTa = 1'b0;
    @(negedge CLK);
    chk("rst2_sb_count",  32'(sb_count), 32'd0);
    chk("rst2_mem_rdata", mem_rdata, 32'h0);
    chk("rst2_dbg_rdata", dbg_rdata, 32'h0);
    #1 RSTa = 1'b1;
    @(negedge CLK);
    cyc(1'b0, 1'b1, 32'h300, 32'h0, 1'b0);
    chk("rst_drained", mem_rdata, 32'hB0);
    cyc(1'b0, 1'b1, 32'h304, 32'h0, 1'b0);
    chk("rst_discard1", mem_rdata, BUF ? 32'hC0DE0304 : 32'hB1);
    cyc(1'b0, 1'b1, 32'h308, 32'h0, 1'b0);
    chk("rst_discard2", mem_rdata, BUF ? 32'hC0DE0308 : 32'hB2);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog @%0t: got still running, want finished", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
